// File: rtl/johnson_phase_sequencer.sv
// Command-driven stepper for a 4-bit Johnson phase register (forward/reverse, programmable rate).
// Optional illegal-phase checker enabled by defining JOHNSON_ERR_CHECK_EN.
module johnson_phase_sequencer #(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [STEP_W-1:0] i_cmd_steps,
    input  logic              i_cmd_dir,
    input  logic [DIV_W-1:0]  i_cmd_div,
    input  logic              i_abort,
    output logic [3:0]        o_phase,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [STEP_W-1:0] o_steps_left,
    output logic              o_phase_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_phase;
    logic [3:0]          w_phase_nxt;
    logic [DIV_W-1:0]    r_presc;
    logic [DIV_W-1:0]    w_presc_nxt;
    logic [DIV_W-1:0]    r_div_q;
    logic [DIV_W-1:0]    w_div_nxt;
    logic                r_dir_q;
    logic                w_dir_nxt;
    logic [STEP_W-1:0]   r_steps_left;
    logic [STEP_W-1:0]   w_steps_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_aborted;
    logic                w_aborted_nxt;
    logic                w_tick;
    logic [3:0]          w_phase_step;

`ifdef JOHNSON_ERR_CHECK_EN
    logic                r_phase_err;
    logic                w_err_nxt;
    logic                w_phase_legal;

    // The eight codes reachable from 0000 by Johnson stepping.
    function automatic logic is_legal(input logic [3:0] p);
        logic ok;
        case (p)
            4'b0000, 4'b1000, 4'b1100, 4'b1110,
            4'b1111, 4'b0111, 4'b0011, 4'b0001: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_phase_legal = is_legal(r_phase);
`endif

    assign w_tick       = (r_presc == r_div_q);
    assign w_phase_step = r_dir_q ? {r_phase[2:0], ~r_phase[3]}
                                  : {~r_phase[0], r_phase[3:1]};

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_presc_nxt   = r_presc;
        w_div_nxt     = r_div_q;
        w_dir_nxt     = r_dir_q;
        w_steps_nxt   = r_steps_left;
        w_aborted_nxt = r_aborted;
`ifdef JOHNSON_ERR_CHECK_EN
        w_err_nxt     = r_phase_err;
`endif

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_div_nxt     = i_cmd_div;
                    w_dir_nxt     = i_cmd_dir;
                    w_steps_nxt   = i_cmd_steps;
                    w_presc_nxt   = '0;
                    w_aborted_nxt = 1'b0;
                    w_state_nxt   = (i_cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    // Abort wins over a coincident tick: no step is issued.
                    w_state_nxt   = S_DONE;
                    w_aborted_nxt = 1'b1;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    w_phase_nxt = w_phase_step;
                    if (r_steps_left != '0) begin
                        w_steps_nxt = r_steps_left - STEP_W'(1);
                    end
                    if (r_steps_left <= STEP_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_presc_nxt = r_presc + DIV_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef JOHNSON_ERR_CHECK_EN
        // Illegal code recovery overrides tick and abort.
        if (!w_phase_legal) begin
            w_phase_nxt = 4'b0000;
            w_err_nxt   = 1'b1;
            if (r_state == S_RUN) begin
                w_state_nxt   = S_DONE;
                w_aborted_nxt = 1'b1;
            end
        end
`endif

        w_busy_nxt = (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_phase      <= 4'b0000;
            r_presc      <= '0;
            r_div_q      <= '0;
            r_dir_q      <= 1'b0;
            r_steps_left <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_presc      <= w_presc_nxt;
            r_div_q      <= w_div_nxt;
            r_dir_q      <= w_dir_nxt;
            r_steps_left <= w_steps_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

`ifdef JOHNSON_ERR_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase_err <= 1'b0;
        end else begin
            r_phase_err <= w_err_nxt;
        end
    end

    assign o_phase_err = r_phase_err;
`else
    assign o_phase_err = 1'b0;
`endif

    assign o_cmd_ready  = (r_state == S_IDLE) && !i_reset;
    assign o_phase      = r_phase;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_aborted    = r_aborted;
    assign o_steps_left = r_steps_left;

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Scoreboard bench for johnson_phase_sequencer: expected phases queued at command issue, popped on each step.
module tb_johnson_phase_sequencer;

    localparam int unsigned STEP_W = 16;
    localparam int unsigned DIV_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic              cmd_dir = 1'b0;
    logic [DIV_W-1:0]  cmd_div = '0;
    logic              abort = 1'b0;
    logic [3:0]        phase;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [STEP_W-1:0] steps_left;
    logic              phase_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] m_phase  = 4'b0000;
    logic [3:0] q_phase[$];

    johnson_phase_sequencer #(.STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_steps(cmd_steps), .i_cmd_dir(cmd_dir), .i_cmd_div(cmd_div), .i_abort(abort),
        .o_phase(phase), .o_busy(busy), .o_done(done), .o_aborted(aborted),
        .o_steps_left(steps_left), .o_phase_err(phase_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] step_model(input logic [3:0] p, input bit rev);
        logic [3:0] n;
        if (!rev) n = {~p[0], p[3], p[2], p[1]};
        else      n = {p[2], p[1], p[0], ~p[3]};
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready cyc%0d got=%b exp=0", i, cmd_ready);
            end
        end
        n_checks++;
        if (phase !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || steps_left !== '0 ||
            aborted !== 1'b0 || phase_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got phase=%b busy=%b done=%b left=%0d ab=%b err=%b exp 0000/0/0/0/0/0",
                     phase, busy, done, steps_left, aborted, phase_err);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready);
        end
        m_phase = 4'b0000;
    endtask

    // Issue one command and follow it to its done pulse; abort_after<0 means no abort.
    task automatic run_cmd(input string name, input int steps, input bit dir,
                           input int div, input int abort_after);
        int         edges = 0;
        int         last = 0;
        int         ticks = 0;
        int         budget;
        int         exp_left;
        int         exp_edge;
        bit         exp_ab;
        bit         fin = 0;
        logic [3:0] prev;
        logic [3:0] exp_p;

        exp_ab = (abort_after >= 0) && (abort_after < steps);
        q_phase.delete();
        for (int k = 0; k < steps; k++) begin
            if (exp_ab && k >= abort_after) break;
            m_phase = step_model(m_phase, dir);
            q_phase.push_back(m_phase);
        end
        exp_left = exp_ab ? steps - abort_after : 0;
        exp_edge = exp_ab ? abort_after * (div + 1) + 1 : steps * (div + 1);
        budget   = steps * (div + 1) + 20;

        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_ready got=%b exp=1", name, cmd_ready);
        end
        prev      = phase;
        cmd_valid = 1'b1;
        cmd_steps = STEP_W'(steps);
        cmd_dir   = dir;
        cmd_div   = DIV_W'(div);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        while (!fin && edges <= budget) begin
            if (phase !== prev) begin
                n_checks++;
                if (q_phase.size() == 0) begin
                    n_fail++; $display("FAIL %s_extra_step got=%b exp=no change", name, phase);
                end else begin
                    exp_p = q_phase.pop_front();
                    if (phase !== exp_p || (edges - last) != div + 1) begin
                        n_fail++;
                        $display("FAIL %s_step%0d got phase=%b gap=%0d exp phase=%b gap=%0d",
                                 name, ticks, phase, edges - last, exp_p, div + 1);
                    end
                end
                last = edges;
                ticks++;
                prev = phase;
                if (exp_ab && ticks == abort_after) abort = 1'b1;
            end
            if (done === 1'b1) begin
                fin = 1;
            end else begin
                n_checks++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    n_fail++; $display("FAIL %s_run got busy=%b ready=%b exp 1/0", name, busy, cmd_ready);
                end
                @(posedge clk); #1;
                abort = 1'b0;
                edges++;
            end
        end
        abort = 1'b0;

        n_checks++;
        if (!fin) begin
            n_fail++; $display("FAIL %s_timeout got no done exp done by %0d cycles", name, budget);
        end else if (busy !== 1'b0 || aborted !== exp_ab || steps_left !== STEP_W'(exp_left) ||
                     q_phase.size() != 0 || edges != exp_edge) begin
            n_fail++;
            $display("FAIL %s_done got busy=%b ab=%b left=%0d pend=%0d edge=%0d exp 0/%b/%0d/0/%0d",
                     name, busy, aborted, steps_left, q_phase.size(), edges, exp_ab, exp_left, exp_edge);
        end

        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || aborted !== exp_ab || phase !== m_phase) begin
            n_fail++;
            $display("FAIL %s_after got done=%b ready=%b ab=%b phase=%b exp 0/1/%b/%b",
                     name, done, cmd_ready, aborted, phase, exp_ab, m_phase);
        end
    endtask

    task automatic test_forward();
        run_cmd("fwd5", 5, 1'b0, 0, -1);
    endtask

    task automatic test_reverse();
        run_cmd("rev8", 8, 1'b1, 2, -1);
        n_checks++;
        if (phase !== 4'b0111) begin
            n_fail++; $display("FAIL rev8_return got=%b exp=0111", phase);
        end
    endtask

    task automatic test_zero_steps();
        run_cmd("zero", 0, 1'b0, 3, -1);
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_a", 3, 1'b1, 1, -1);
        run_cmd("b2b_b", 6, 1'b0, 4, -1);
    endtask

    task automatic test_abort();
        test_reset();
        run_cmd("abort", 10, 1'b0, 0, 4);
        n_checks++;
        if (phase !== 4'b1111 || steps_left !== STEP_W'(6)) begin
            n_fail++; $display("FAIL abort_final got phase=%b left=%0d exp 1111/6", phase, steps_left);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle got done=%b busy=%b ready=%b exp 0/0/1", done, busy, cmd_ready);
        end
    endtask

    task automatic test_phase_err();
`ifdef JOHNSON_ERR_CHECK_EN
        int seen = 0;
        cmd_valid = 1'b1; cmd_steps = STEP_W'(10); cmd_dir = 1'b0; cmd_div = DIV_W'(0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        force dut.r_phase = 4'b0101;
        #1;
        release dut.r_phase;
        for (int i = 0; i < 4 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1;
        end
        n_checks++;
        if (seen == 0 || phase !== 4'b0000 || phase_err !== 1'b1 || aborted !== 1'b1) begin
            n_fail++;
            $display("FAIL err_detect got done=%0d phase=%b err=%b ab=%b exp 1/0000/1/1",
                     seen, phase, phase_err, aborted);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (phase_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got=%b exp=1", phase_err);
        end
        m_phase = 4'b0000;
`else
        n_checks++;
        if (phase_err !== 1'b0) begin
            n_fail++; $display("FAIL err_tied got=%b exp=0", phase_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_zero_steps();
        test_back_to_back();
        test_abort();
        test_phase_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
